// File: rtl/rr_grant_encoder_pkg.sv
// Package rr_grant_pkg: shared constants, FSM state type and index helper
// for the round-robin grant encoder slice.
//   IDX_W_DEF : default grant index width (8 requesters)
//   state_t   : arbiter FSM states
//   idx_inc   : wrap-around increment of a requester index
package rr_grant_pkg;

    localparam int IDX_W_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Next index in the rotation, wrapping from n-1 back to 0.
    function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_grant_encoder_if.sv
// Interface rr_grant_if: request/grant bundle between the requesters and the
// round-robin grant encoder.
//   req         : request vector, bit i = requester i wants ownership
//   rel         : current owner is done (only looked at while grant_valid=1)
//   grant_idx   : registered index of the current/last owner (decoder select)
//   grant_valid : grant_idx is a live grant (gates the decoder output)
//   timeout     : one-cycle pulse, grant revoked by hold timeout
//   state       : arbiter FSM state, exported for observation
//
// Handshake: a grant exists exactly while grant_valid=1. The owner keeps it
// by holding req[grant_idx]=1 and rel=0; it gives it up by raising rel or
// dropping its req bit, and the arbiter answers with grant_valid=0 on the
// following cycle. grant_valid never goes from one live grant to the next
// without at least one low cycle in between.
interface rr_grant_if #(
    parameter int IDX_W = rr_grant_pkg::IDX_W_DEF
);
    import rr_grant_pkg::*;

    logic [2**IDX_W-1:0] req;
    logic                rel;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic                timeout;
    state_t              state;

    modport master (
        output req, rel,
        input  grant_idx, grant_valid, timeout, state
    );

    modport slave (
        input  req, rel,
        output grant_idx, grant_valid, timeout, state
    );

endinterface

// File: rtl/rr_grant_encoder_pick.sv
// Module rr_priority_pick: combinational rotating-priority search.
//   req     : request vector (2**IDX_W bits)
//   ptr     : last owner; search starts at ptr+1 and ends at ptr
//   winner  : first asserted request in rotation order
//   any_req : at least one request bit is set
// The request vector is rotated so the search start sits at bit 0, a plain
// lowest-set-bit encoder runs on it, and the offset is added back to the start.
module rr_priority_pick
    import rr_grant_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [2**IDX_W-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [IDX_W-1:0]    winner,
    output logic                any_req
);

    localparam int N_REQ = 2**IDX_W;

    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic             found;

    assign start   = IDX_W'(idx_inc(32'(ptr), N_REQ));
    assign any_req = |req;

    always_comb begin
        rot   = '0;
        off   = '0;
        found = 1'b0;
        // IDX_W-bit sum wraps modulo N_REQ, giving the rotation for free.
        for (int k = 0; k < N_REQ; k++) begin
            rot[k] = req[start + IDX_W'(k)];
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                off   = IDX_W'(k);
                found = 1'b1;
            end
        end
        winner = start + off;
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Module rr_grant_encoder: round-robin arbiter producing a registered grant
// index plus valid flag for a downstream 3-to-8 decoder.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rr_grant_if slave modport (req, rel in; grant_idx, grant_valid,
//         timeout, state out)
// A grant lasts until the owner releases, drops its request, or has been
// valid for MAX_HOLD cycles. Every exit passes through IDLE for one cycle,
// so the decoded one-hot lines always see a dead cycle between owners.
module rr_grant_encoder
    import rr_grant_pkg::*;
#(
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    rr_grant_if.slave  bus
);

    localparam int N_REQ  = 2**IDX_W;
    localparam int HOLD_W = $clog2(MAX_HOLD);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              to_q, to_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic              exit_rel, exit_drop, exit_to;

    rr_priority_pick #(.IDX_W(IDX_W)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign exit_rel  = bus.rel;
    assign exit_drop = !bus.req[idx_q];
    // cnt_q counts the valid cycles already served minus one, so this edge
    // ends the MAX_HOLD-th valid cycle.
    assign exit_to   = (cnt_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            idx_q   <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (exit_rel || exit_drop || exit_to) begin
                    // idx_q is kept so the decoder select stays put during
                    // the dead cycle; ptr moves so the search skips past it.
                    state_d = IDLE;
                    ptr_d   = idx_q;
                    to_d    = exit_to && !exit_rel && !exit_drop;
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = (state_q == GRANT);
    assign bus.timeout     = to_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
module tb_rr_grant_encoder;
    import rr_grant_pkg::*;

    localparam int IDX_W    = 3;
    localparam int N        = 8;
    localparam int MAX_HOLD = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_grant_if #(.IDX_W(IDX_W)) bus();

    rr_grant_encoder #(.IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [4:0] exp_q[$];     // {grant_valid, grant_idx[2:0], timeout}
    int checks = 0;
    int errors = 0;

    // Reference model: tracks owner, rotation origin and valid-cycle age.
    bit m_valid = 0;
    int m_idx   = 0;
    int m_ptr   = N - 1;
    int m_age   = 0;
    bit m_to    = 0;

    // Grant log for the fairness phase.
    bit log_en = 0;
    int got_q[$];

    task automatic model_step(input logic r, input logic [7:0] q, input logic rl);
        if (r) begin
            m_valid = 0; m_idx = 0; m_to = 0; m_ptr = N - 1; m_age = 0;
        end else if (!m_valid) begin
            m_to = 0;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (q[j]) begin
                    m_idx = j; m_valid = 1; m_age = 1;
                    break;
                end
            end
        end else begin
            bit drop;
            drop = !q[m_idx];
            if (rl || drop || m_age == MAX_HOLD) begin
                m_to    = (m_age == MAX_HOLD) && !rl && !drop;
                m_valid = 0;
                m_ptr   = m_idx;
            end else begin
                m_age++;
                m_to = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [7:0] q, input logic rl);
        @(negedge clk);
        rst     = r;
        bus.req = q;
        bus.rel = rl;
        @(posedge clk);
        model_step(r, q, rl);
        exp_q.push_back({m_valid, 3'(m_idx), m_to});
    endtask

    task automatic idle_cycles(input logic [7:0] q, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, q, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [4:0] e;
        bit prev_valid;
        prev_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.grant_valid !== e[4]) begin
                    errors++;
                    $display("FAIL grant_valid t=%0t got %b want %b", $time, bus.grant_valid, e[4]);
                end
                checks++;
                if (bus.grant_idx !== e[3:1]) begin
                    errors++;
                    $display("FAIL grant_idx t=%0t got %0d want %0d", $time, bus.grant_idx, e[3:1]);
                end
                checks++;
                if (bus.timeout !== e[0]) begin
                    errors++;
                    $display("FAIL timeout t=%0t got %b want %b", $time, bus.timeout, e[0]);
                end
            end
            if (log_en && bus.grant_valid === 1'b1 && !prev_valid) got_q.push_back(int'(bus.grant_idx));
            prev_valid = (bus.grant_valid === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int fair_exp[9];
        fair_exp = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        bus.req = '0;
        bus.rel = 1'b0;

        // 1. reset with all requests up, then first grant goes to idx 0
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        idle_cycles(8'hFF, 3);

        // 2. single requester 2: grant, release, re-grant
        drive(1'b1, 8'h00, 1'b0);
        idle_cycles(8'h04, 3);
        drive(1'b0, 8'h04, 1'b1);
        idle_cycles(8'h04, 3);
        drive(1'b0, 8'h00, 1'b0);

        // 3. fairness: all requesting, release on every granted cycle
        drive(1'b1, 8'h00, 1'b0);
        log_en = 1;
        for (int i = 0; i < 18; i++) drive(1'b0, 8'hFF, m_valid);
        @(negedge clk);
        log_en = 0;
        checks++;
        if (got_q.size() < 9) begin
            errors++;
            $display("FAIL fair_count got %0d want >=9", got_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (got_q[i] != fair_exp[i]) begin
                    errors++;
                    $display("FAIL fair_seq[%0d] got %0d want %0d", i, got_q[i], fair_exp[i]);
                end
            end
        end

        // 4. timeout on a lone requester, then release coinciding with limit
        drive(1'b1, 8'h00, 1'b0);
        idle_cycles(8'h01, 12);
        for (int i = 0; i < 12; i++) drive(1'b0, 8'h01, m_valid && (m_age == MAX_HOLD));

        // 5. request drop: owner 5, drop it, idx 6 beats earlier idx 1
        drive(1'b1, 8'h00, 1'b0);
        idle_cycles(8'h60, 2);
        idle_cycles(8'h42, 3);

        // 6. reset mid-grant (owner 6, ptr 5), next grant lowest index 3
        drive(1'b1, 8'h48, 1'b0);
        idle_cycles(8'h48, 3);

        // 7. randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] q;
            q = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) q = q & 8'($urandom);
            drive(($urandom_range(0, 80) == 0), q, ($urandom_range(0, 4) == 0));
        end
        idle_cycles(8'h00, 3);

        // let the monitor drain the last entry
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d left want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
